// File: rtl/hack_pkg.sv
// hack_pkg: shared types and widths for the program loader and its neighbours
package hack_pkg;

  localparam int WORD_W      = 16;
  localparam int HACK_ADDR_W = 15;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a counted, checksummed byte stream and writes it into instruction memory
module prog_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W    = HACK_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_n;
  logic [7:0]        hi;
  logic [7:0]        sum;
  logic [WORD_W-1:0] count;
  logic [WORD_W-1:0] idx;
  logic [WORD_W-1:0] word;
  logic              acc;
  logic              rearm;

  assign acc   = rx_valid && rx_ready;
  assign word  = {hi, rx_data};
  assign rearm = (state == DONE || state == ERR) && reload;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR_HI;
    else        state <= state_n;
  end

  // next-state: stream states move only on an accepted byte, terminal states wait for reload
  always_comb begin
    state_n = state;
    case (state)
      HDR_HI:    if (acc) state_n = HDR_LO;
      HDR_LO:    if (acc) state_n = (word == '0) ? CHK : (32'(word) > MAX_WORDS) ? ERR : DAT_HI;
      DAT_HI:    if (acc) state_n = DAT_LO;
      DAT_LO:    if (acc) state_n = (idx == count - 1'b1) ? CHK : DAT_HI;
      CHK:       if (acc) state_n = (rx_data == sum) ? DONE : ERR;
      DONE, ERR: if (reload) state_n = HDR_HI;
      default:   state_n = HDR_HI;
    endcase
  end

  // status outputs are pure functions of state; the CPU runs only after a good load
  always_comb begin
    rx_ready    = !(state == DONE || state == ERR);
    busy        = rx_ready;
    done        = state == DONE;
    err         = state == ERR;
    cpu_reset_n = state == DONE;
  end

  // datapath: byte capture, running checksum, word index and the one-cycle memory write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= '0;
      sum       <= '0;
      count     <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (acc && state != CHK) sum <= sum + rx_data;
      if (acc && (state == HDR_HI || state == DAT_HI)) hi <= rx_data;
      if (acc && state == HDR_LO) count <= word;
      if (acc && state == DAT_LO) begin
        mem_we    <= 1'b1;
        mem_wdata <= word;
        mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        idx       <= idx + 1'b1;
      end
      if (rearm) begin
        idx   <= '0;
        count <= '0;
        sum   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams with a write scoreboard checked by an independent monitor
module tb_prog_loader;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic        reload = 0;
  logic        sel = 0;
  logic        rx_ready, mem_we, cpu_reset_n, busy, done, err;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        rx_ready4, mem_we4, cpu_reset_n4, busy4, done4, err4;
  logic [14:0] mem_addr4;
  logic [15:0] mem_wdata4;
  logic        rdy;
  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  logic [7:0]  s[$];

  assign rdy = sel ? rx_ready4 : rx_ready;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid && !sel), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  prog_loader #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid && sel), .rx_data(rx_data),
    .rx_ready(rx_ready4), .reload(1'b0), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .cpu_reset_n(cpu_reset_n4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push(input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1;
    rx_data  = b;
    while (!rdy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("rx_ready_timeout", 32'(rdy), 1);
    @(negedge clk);
    rx_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_all(input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic pulse_reload();
    reload = 1;
    @(negedge clk);
    reload = 0;
  endtask

  task automatic push_std();
    push(15'd0, 16'h1234);
    push(15'd1, 16'hABCD);
    push(15'd2, 16'h0001);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // monitor: every write strobe must match the next expected write; dut4 must never write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got %0h@%0h expected none", mem_wdata, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.a || mem_wdata !== e.d) begin
            bad++;
            $display("FAIL write: got %0h@%0h expected %0h@%0h", mem_wdata, mem_addr, e.d, e.a);
          end
        end
      end
      if (mem_we4) begin
        total++;
        bad++;
        $display("FAIL dut4_write: got %0h@%0h expected none", mem_wdata4, mem_addr4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1;
    @(negedge clk);

    push_std();
    s = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC2};
    send_all(0);
    chk("good_done", 32'(done), 1);
    chk("good_cpu_reset_n", 32'(cpu_reset_n), 1);
    chk("good_busy", 32'(busy), 0);
    chk("good_rx_ready", 32'(rx_ready), 0);
    chk("good_pending", 32'(exp_q.size()), 0);

    pulse_reload();
    chk("reload_cpu_reset_n", 32'(cpu_reset_n), 0);
    chk("reload_busy", 32'(busy), 1);
    push_std();
    s = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC3};
    send_all(0);
    chk("badsum_err", 32'(err), 1);
    chk("badsum_done", 32'(done), 0);
    chk("badsum_cpu_reset_n", 32'(cpu_reset_n), 0);
    chk("badsum_rx_ready", 32'(rx_ready), 0);
    chk("badsum_pending", 32'(exp_q.size()), 0);

    pulse_reload();
    s = {8'h00, 8'h00, 8'h00};
    send_all(0);
    chk("empty_done", 32'(done), 1);
    chk("empty_err", 32'(err), 0);

    sel = 1;
    s = {8'h00, 8'h05};
    send_all(0);
    chk("over_err", 32'(err4), 1);
    chk("over_rx_ready", 32'(rx_ready4), 0);
    chk("over_done", 32'(done4), 0);
    chk("over_cpu_reset_n", 32'(cpu_reset_n4), 0);
    chk("over_busy", 32'(busy4), 0);
    sel = 0;

    pulse_reload();
    push_std();
    s = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC2};
    send_all(1);
    chk("gap_done", 32'(done), 1);
    chk("gap_pending", 32'(exp_q.size()), 0);

    pulse_reload();
    push(15'd0, 16'h1234);
    s = {8'h00, 8'h03, 8'h12, 8'h34};
    send_all(0);
    @(negedge clk);
    chk("mid_pending", 32'(exp_q.size()), 0);
    reset = 0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    push_std();
    s = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC2};
    send_all(0);
    chk("restart_done", 32'(done), 1);
    chk("restart_pending", 32'(exp_q.size()), 0);

    pulse_reload();
    chk("relo_cpu_reset_n", 32'(cpu_reset_n), 0);
    chk("relo_done", 32'(done), 0);
    push(15'd0, 16'hFFFF);
    s = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
    send_all(0);
    chk("ffff_done", 32'(done), 1);
    chk("ffff_cpu_reset_n", 32'(cpu_reset_n), 1);
    chk("ffff_pending", 32'(exp_q.size()), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, instruction-memory address width.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, first memory address written.
REQ-003 The block SHALL have parameter MAX_WORDS, default 32768, largest legal word count.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_valid  input  1  byte available from serial receiver.
REQ-007 The block SHALL have port rx_data  input  8  received byte.
REQ-008 The block SHALL have port rx_ready  output  1  loader accepts byte this cycle.
REQ-009 The block SHALL have port reload  input  1  single-cycle request to start a new load.
REQ-010 The block SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  write address.
REQ-012 The block SHALL have port mem_wdata  output  16  instruction word.
REQ-013 The block SHALL have port cpu_reset_n  output  1  hold CPU in reset while low.
REQ-014 The block SHALL have port busy  output  1  load in progress.
REQ-015 The block SHALL have port done  output  1  load completed, checksum good.
REQ-016 The block SHALL have port err  output  1  load aborted.

Function
REQ-017 A byte SHALL be accepted on a rising clk edge where rx_valid and rx_ready are both 1; no other byte is consumed.
REQ-018 Stream format SHALL be: count N (2 bytes, high first), N words (2 bytes each, high first), 1 checksum byte.
REQ-019 FSM states SHALL be HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK, DONE, ERR; each HDR/DAT/CHK state advances only on an accepted byte.
REQ-020 rx_ready SHALL be 1 in HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK and 0 in DONE, ERR.
REQ-021 After HDR_LO: N=0 -> CHK; N>MAX_WORDS -> ERR; otherwise -> DAT_HI.
REQ-022 On accepting the DAT_LO byte, mem_we SHALL be 1 for exactly the next cycle, with mem_wdata={high byte, low byte} and mem_addr=BASE_ADDR+word index.
REQ-023 Word index SHALL start at 0 and increment after each write; after word N-1 the FSM SHALL go to CHK.
REQ-024 mem_addr arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-025 Checksum SHALL be the 8-bit modulo-256 sum of all header and data bytes; match -> DONE, mismatch -> ERR.
REQ-026 cpu_reset_n SHALL be 0 in every state except DONE, rising the cycle DONE is entered.
REQ-027 busy SHALL be 1 in HDR/DAT/CHK states; done=1 only in DONE; err=1 only in ERR.
REQ-028 reload in DONE or ERR SHALL move to HDR_HI next cycle, clearing index, count and checksum, and dropping cpu_reset_n; reload in other states SHALL be ignored.
REQ-029 mem_we SHALL be 0 in all cycles not covered by REQ-022.

Reset
REQ-030 While reset=0: state=HDR_HI, rx_ready=1, busy=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset_n=0, done=0, err=0, index/count/checksum=0.
REQ-031 Reset asserted mid-load SHALL abandon the partial load; the next stream SHALL restart at BASE_ADDR.

Structure
REQ-032 The FSM state enum, the 16-bit word width and the default ADDR_W SHALL live in the shared hack_pkg package.
REQ-033 The block SHALL be a single module with an inline checksum accumulator; no sub-module.

Verification
REQ-034 Send 00 03 12 34 AB CD 00 01 C2 -> writes 0x1234@0, 0xABCD@1, 0x0001@2; done=1; cpu_reset_n=1.
REQ-035 Same stream with checksum C3 -> three writes, then err=1, cpu_reset_n=0, rx_ready=0.
REQ-036 Send 00 00 00 -> no writes, done=1. With MAX_WORDS=4, send 00 05 -> err=1 right after byte 2, no writes.
REQ-037 Load REQ-034 with rx_valid toggling every other cycle -> identical writes; no byte lost or duplicated.
REQ-038 Assert reset after first word written, then resend REQ-034 -> reset values, then writes restart at 0.
REQ-039 Pulse reload in DONE -> cpu_reset_n=0 next cycle; new stream 00 01 FF FF FF -> 0xFFFF@0, done=1.
